button_reader: RTL
==================

Name: button_reader

Overview:
- Input-side counterpart to the board blinker. It reads one on-board pushbutton pin and turns it into clean, debounced, registered events for the rest of the design: pressed level, press/release/click/long-press pulses, and a press counter.
- Runs from the 16 MHz board clock and sits directly behind the top-level pin.

Parameters:
- CLK_HZ, 16_000_000, input clock frequency in Hz.
- DEBOUNCE_MS, 10, time the input must be stable to accept a press or a release.
- LONG_MS, 1000, time held after the accepted press before the long-press event.
- ACTIVE_LOW, 1, 1 = pin reads 0 when pressed; 0 = pin reads 1 when pressed.

Ports:
- CLK  input  1  board clock, all logic on posedge.
- RESETN  input  1  asynchronous active-low reset.
- BTN  input  1  raw asynchronous button pin.
- pressed  output  1  debounced button level, 1 = held.
- press_pulse  output  1  one-cycle pulse when a press is accepted.
- release_pulse  output  1  one-cycle pulse when a release is accepted.
- click_pulse  output  1  one-cycle pulse on release of a press that never reached long.
- long_pulse  output  1  one-cycle pulse when a hold reaches LONG_MS.
- press_count  output  8  accepted-press counter, wraps 255 -> 0.

Behaviour:
- Interface is fixed: one clock, CLK. Reset RESETN is asynchronous and active-low.
- Reset state:
  - FSM in IDLE.
  - Cycle counter = 0; was_long = 0.
  - All outputs = 0.
  - Sync flops = released level (1 if ACTIVE_LOW, else 0).
- Derived constants:
  - DEB_CYC = (CLK_HZ/1000)*DEBOUNCE_MS.
  - LONG_CYC = (CLK_HZ/1000)*LONG_MS.
  - Counter width = clog2(max(DEB_CYC, LONG_CYC)+1). Saturates, never wraps.
- Input path: BTN passes through a 2-flop synchronizer, then is normalized to act = sync ^ ACTIVE_LOW, so 1 = pressed.
- Counter: cleared on every state transition, increments by 1 each cycle while the state is held.
- FSM states IDLE, DEB_PRESS, HELD, LONG, DEB_RELEASE:
  - IDLE: act=1 -> DEB_PRESS.
  - DEB_PRESS:
    - act=0 -> IDLE. Bounce rejected, no outputs change.
    - act=1 and counter==DEB_CYC-1 -> HELD. Assert pressed=1 and press_pulse, increment press_count, clear was_long.
  - HELD:
    - act=0 -> DEB_RELEASE.
    - counter==LONG_CYC-1 -> LONG. Assert long_pulse, set was_long=1.
    - If both conditions hold in the same cycle, act=0 wins and there is no long_pulse.
  - LONG: act=0 -> DEB_RELEASE.
  - DEB_RELEASE:
    - act=1 -> return to LONG if was_long, else HELD. No pulses; the counter clears, so the long timer restarts.
    - act=0 and counter==DEB_CYC-1 -> IDLE. Assert pressed=0 and release_pulse; also assert click_pulse if was_long=0.
- Outputs are registered. Every pulse is high for exactly one cycle, in the cycle after the transition edge.
- Latency: BTN becomes active and stable before edge k.
  - DEB_PRESS is entered at edge k+2.
  - press_pulse is high in the cycle after edge k+2+DEB_CYC.
  - Release timing is symmetric.
- pressed changes only together with press_pulse/release_pulse. It stays 1 through DEB_RELEASE bounces.
- RESETN asserted mid-press: everything returns to the reset state immediately, with no release pulse. After deassertion a still-held button is treated as a new press, with full debounce.
- Glitches shorter than DEB_CYC cycles never produce any output change.

Decomposition:
- Package button_reader_pkg holds:
  - the state enum (IDLE, DEB_PRESS, HELD, LONG, DEB_RELEASE);
  - functions computing DEB_CYC, LONG_CYC and the counter width from the parameters.
- One sub-module, sync_2ff: two-flop synchronizer with async active-low reset and a reset-value parameter. Reused later for other pins.

Test Plan (sim params: CLK_HZ=1000, DEBOUNCE_MS=4, LONG_MS=20, ACTIVE_LOW=1; all counts below are CLK cycles):
- Reset check: hold RESETN=0 with BTN=1, release reset -> all outputs 0, press_count=0; no pulses for 50 cycles.
- Short click:
  - BTN=0 before edge 10, held 10 cycles -> press_pulse high only in the cycle after edge 16, press_count=1, pressed=1.
  - Then BTN=1 -> release_pulse and click_pulse together 6 cycles after the release edge, pressed=0, long_pulse never asserted.
- Bounce rejection:
  - BTN toggles every 2 cycles for 20 cycles -> no pulses, pressed stays 0.
  - A 1-cycle high glitch during HELD -> no release, pressed stays 1.
- Long press: BTN=0 held for 40 cycles -> press_pulse, then long_pulse exactly 20 cycles later; on release, release_pulse without click_pulse.
- Wrap and reset mid-press:
  - 256 clean clicks -> press_count returns to 0.
  - Assert RESETN=0 while in HELD -> outputs clear at once, no release_pulse.
  - Deassert RESETN with BTN still 0 -> new press_pulse after 2+4 cycles.

Source files
------------

// File: rtl/button_reader_pkg.sv
// Shared types and derived timing constants for the pushbutton reader.
// The debounce and long-press cycle counts are derived from the clock rate.
package button_reader_pkg;

    typedef enum logic [2:0] {
        StIdle,
        StDebPress,
        StHeld,
        StLong,
        StDebRelease
    } state_e;

    function automatic int unsigned calc_deb_cyc(input int unsigned clk_hz,
                                                 input int unsigned debounce_ms);
        return (clk_hz / 1000) * debounce_ms;
    endfunction

    function automatic int unsigned calc_long_cyc(input int unsigned clk_hz,
                                                  input int unsigned long_ms);
        return (clk_hz / 1000) * long_ms;
    endfunction

    function automatic int unsigned calc_cnt_width(input int unsigned deb_cyc,
                                                   input int unsigned long_cyc);
        int unsigned m;
        m = (deb_cyc > long_cyc) ? deb_cyc : long_cyc;
        return $clog2(m + 1);
    endfunction

endpackage

// File: rtl/sync_2ff.sv
// Two-flop synchronizer for an asynchronous input.
// The reset value is a parameter so the output can start at the pin's idle level.
module sync_2ff #(
    parameter bit RESET_VAL = 1'b0
) (
    input  logic i_clk,
    input  logic i_rst_n,
    input  logic i_d,
    output logic o_q
);

    logic r_meta;
    logic r_q;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_meta <= RESET_VAL;
            r_q    <= RESET_VAL;
        end else begin
            r_meta <= i_d;
            r_q    <= r_meta;
        end
    end

    assign o_q = r_q;

endmodule

// File: rtl/button_reader.sv
// Debounced pushbutton reader: level, press/release/click/long pulses and a press counter.
// All outputs are registered; every pulse lasts exactly one cycle.
module button_reader
    import button_reader_pkg::*;
#(
    parameter int unsigned CLK_HZ      = 16_000_000,
    parameter int unsigned DEBOUNCE_MS = 10,
    parameter int unsigned LONG_MS     = 1000,
    parameter bit          ACTIVE_LOW  = 1'b1
) (
    input  logic       CLK,
    input  logic       RESETN,
    input  logic       BTN,
    output logic       pressed,
    output logic       press_pulse,
    output logic       release_pulse,
    output logic       click_pulse,
    output logic       long_pulse,
    output logic [7:0] press_count
);

    localparam int unsigned DebCyc  = calc_deb_cyc(CLK_HZ, DEBOUNCE_MS);
    localparam int unsigned LongCyc = calc_long_cyc(CLK_HZ, LONG_MS);
    localparam int unsigned CntW    = calc_cnt_width(DebCyc, LongCyc);

    localparam logic [CntW-1:0] DebLast  = CntW'(DebCyc - 1);
    localparam logic [CntW-1:0] LongLast = CntW'(LongCyc - 1);
    localparam logic [CntW-1:0] CntMax   = '1;

    logic w_btn_sync;
    logic w_act;

    state_e          r_state;
    logic [CntW-1:0] r_cnt;
    logic            r_was_long;
    logic            r_pressed;
    logic            r_press_pulse;
    logic            r_release_pulse;
    logic            r_click_pulse;
    logic            r_long_pulse;
    logic [7:0]      r_press_count;

    // Sync flops reset to the released level so reset never looks like a press.
    sync_2ff #(
        .RESET_VAL (ACTIVE_LOW)
    ) u_sync (
        .i_clk   (CLK),
        .i_rst_n (RESETN),
        .i_d     (BTN),
        .o_q     (w_btn_sync)
    );

    assign w_act = w_btn_sync ^ ACTIVE_LOW;

    always_ff @(posedge CLK or negedge RESETN) begin
        if (!RESETN) begin
            r_state         <= StIdle;
            r_cnt           <= '0;
            r_was_long      <= 1'b0;
            r_pressed       <= 1'b0;
            r_press_pulse   <= 1'b0;
            r_release_pulse <= 1'b0;
            r_click_pulse   <= 1'b0;
            r_long_pulse    <= 1'b0;
            r_press_count   <= '0;
        end else begin
            r_press_pulse   <= 1'b0;
            r_release_pulse <= 1'b0;
            r_click_pulse   <= 1'b0;
            r_long_pulse    <= 1'b0;
            // Counter saturates; each transition below overrides it with a clear.
            if (r_cnt != CntMax) begin
                r_cnt <= r_cnt + 1'b1;
            end
            unique case (r_state)
                StIdle: begin
                    if (w_act) begin
                        r_state <= StDebPress;
                        r_cnt   <= '0;
                    end
                end
                StDebPress: begin
                    if (!w_act) begin
                        r_state <= StIdle;
                        r_cnt   <= '0;
                    end else if (r_cnt == DebLast) begin
                        r_state       <= StHeld;
                        r_cnt         <= '0;
                        r_pressed     <= 1'b1;
                        r_press_pulse <= 1'b1;
                        r_press_count <= r_press_count + 8'd1;
                        r_was_long    <= 1'b0;
                    end
                end
                StHeld: begin
                    if (!w_act) begin
                        r_state <= StDebRelease;
                        r_cnt   <= '0;
                    end else if (r_cnt == LongLast) begin
                        r_state      <= StLong;
                        r_cnt        <= '0;
                        r_long_pulse <= 1'b1;
                        r_was_long   <= 1'b1;
                    end
                end
                StLong: begin
                    if (!w_act) begin
                        r_state <= StDebRelease;
                        r_cnt   <= '0;
                    end
                end
                StDebRelease: begin
                    if (w_act) begin
                        r_state <= r_was_long ? StLong : StHeld;
                        r_cnt   <= '0;
                    end else if (r_cnt == DebLast) begin
                        r_state         <= StIdle;
                        r_cnt           <= '0;
                        r_pressed       <= 1'b0;
                        r_release_pulse <= 1'b1;
                        r_click_pulse   <= !r_was_long;
                    end
                end
                default: begin
                    r_state <= StIdle;
                    r_cnt   <= '0;
                end
            endcase
        end
    end

    assign pressed       = r_pressed;
    assign press_pulse   = r_press_pulse;
    assign release_pulse = r_release_pulse;
    assign click_pulse   = r_click_pulse;
    assign long_pulse    = r_long_pulse;
    assign press_count   = r_press_count;

endmodule
